code_check: RTL and testbench
=============================

# code_check

Password entry and verification stage of the bomb-dismantlement game, directly downstream of the game control block. When `startInput` is raised, it captures the 5-bit `random` code and accepts player guesses from switches, confirmed by a button. It compares each guess, counts remaining tries and honours the countdown's time-up. Its `success`/`fail` levels drive the control block's `insuccess`/`infail` inputs.

## Interface
- `CODE_W`, 5, width of code and guess
- `MAX_TRIES`, 3, guesses allowed per round (≥1; used only with retry feature)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `startInput`  in  1  round enable from control; level
- `random`  in  CODE_W  target code, sampled on `startInput` rising edge
- `guess`  in  CODE_W  player switches, quasi-static
- `btn_submit`  in  1  raw asynchronous confirm button, active-high
- `time_up`  in  1  countdown expired, synchronous level
- `success`  out  1  code matched; held until round ends
- `fail`  out  1  out of tries or time; held until round ends
- `wrong`  out  1  one-cycle pulse per incorrect guess
- `tries_left`  out  $clog2(MAX_TRIES+1)  remaining guesses
- `busy`  out  1  high while in ENTRY

## Operation
- States: IDLE, ENTRY, CHECK, SUCCESS, FAIL.
- IDLE → ENTRY when `startInput`=1 and its registered copy is 0.
  - Latch `random` into `target`.
  - Load `tries_left`=MAX_TRIES.
- ENTRY: on submit pulse, latch `guess` into `entry` and go to CHECK.
- CHECK is one cycle:
  - `entry==target` → SUCCESS.
  - Mismatch → pulse `wrong` and decrement `tries_left`.
  - If the decremented value is 0 → FAIL; else → ENTRY.
- SUCCESS/FAIL are terminal. The outputs stay set until `startInput`=0.
- Priority, highest first:
  1. `startInput`=0 → IDLE from any state. Clears `success`, `fail`, `busy`; `tries_left`=0.
  2. `time_up`=1 in ENTRY or CHECK → FAIL. Overrides a same-cycle submit and a same-cycle match.
  3. Normal transitions.
- `time_up` is ignored in IDLE, SUCCESS and FAIL. `success` and `fail` are never both 1.
- Submit pulse: `btn_submit` passes through a 2-flop synchronizer, then a rising-edge detect. A held button yields exactly one pulse. Pulses outside ENTRY are discarded, not queued.
- `tries_left` never underflows; it saturates at 0.

## Timing
- Reset values: state IDLE, `success`=0, `fail`=0, `wrong`=0, `busy`=0, `tries_left`=0. `target`, `entry` and the synchronizer flops reset to 0.
- Let edge k be the first rising edge that samples `btn_submit` high:
  - sync stage 1 at k, stage 2 at k+1;
  - pulse is valid in the cycle after k+1;
  - state=CHECK after k+2;
  - `success`/`fail`/`wrong` visible after k+3.
- `startInput` rise to `busy`=1: 2 edges (register, then transition).
- `startInput` fall to outputs cleared: 1 edge.
- `time_up` to `fail`=1: 1 edge.
- Minimum button low time between guesses: 2 cycles.

## Configuration
- `CODE_CHECK_RETRY_EN` defined: up to MAX_TRIES guesses per round, as described above.
- Not defined:
  - MAX_TRIES is ignored and `tries_left` loads 1.
  - The first mismatch pulses `wrong` and goes straight to FAIL.
  - All ports are still present.

## Structure
- Package `bomb_pkg` holds:
  - state enum `cc_state_t`;
  - `CODE_W` default constant;
  - `MAX_TRIES` default constant.
- One sub-module, `btn_edge`: 2-flop synchronizer plus rising-edge pulse, async active-low reset. Also reusable for BTN1 elsewhere.

## Test plan
- Correct guess: reset; `random`=5'h13, raise `startInput`; `guess`=5'h13, press for 5 cycles → `success`=1 at k+3, `fail`=0, `wrong` never pulses, `tries_left`=3.
- Two wrong guesses, then correct (retry on): 5'h01, then 5'h02, then 5'h13 → two `wrong` pulses; `tries_left` reads 2 after the first and 1 after the second; then `success`=1.
- Exhaustion: three wrong guesses → `fail`=1 after the third CHECK, `tries_left`=0. A fourth press has no effect.
- Time-up race: `time_up`=1 in the same cycle the submit pulse fires with a correct guess → `fail`=1, `success`=0.
- Abort: drop `startInput` mid-ENTRY, then re-raise it with `random`=5'h07 → outputs cleared; `target`=5'h07 and `tries_left`=3 on re-entry.
- Macro off, with async `rst_n` pulsed mid-round: one wrong guess → FAIL with a single `wrong` pulse. Asserting `rst_n`=0 at any point → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bomb_pkg.sv
// -----------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the bomb-dismantlement game blocks.
//   cc_state_t         : state encoding of the code_check FSM
//   CODE_W_DEFAULT     : default width of the secret code / player guess
//   MAX_TRIES_DEFAULT  : default guesses per round when retries are enabled
// -----------------------------------------------------------------------------
package bomb_pkg;

    localparam int CODE_W_DEFAULT    = 5;
    localparam int MAX_TRIES_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_SUCCESS = 3'd3,
        ST_FAIL    = 3'd4
    } cc_state_t;

endpackage : bomb_pkg

// File: rtl/code_check_btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Brings a raw asynchronous push button into the clk domain through a 2-flop
// synchronizer and turns each press into a single-cycle pulse. A button held
// for many cycles still yields exactly one pulse.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw button level, active-high, asynchronous
//   pulse_o out one-cycle pulse, high in the cycle after the 2nd sync stage
//               first shows the button high
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;   // delayed copy of the synchronized level for edge detect

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule : btn_edge

// File: rtl/code_check.sv
// -----------------------------------------------------------------------------
// code_check
// Password entry / verification stage of the bomb game. A rising edge of
// startInput opens a round: the random code is captured as the target and
// the player submits guesses from switches with a confirm button. Each guess
// is compared in a one-cycle CHECK state; the round ends in SUCCESS on a
// match or FAIL when tries run out or the countdown expires.
//
// Build option:
//   CODE_CHECK_RETRY_EN  defined   -> up to MAX_TRIES guesses per round
//                        undefined -> a single guess; first mismatch fails
//
// Parameters:
//   CODE_W      width of code and guess
//   MAX_TRIES   guesses per round (>=1, only meaningful with retries)
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   startInput  in   round enable level from game control
//   random      in   target code, captured when the round opens
//   guess       in   player switches
//   btn_submit  in   raw confirm button
//   time_up     in   countdown expired (synchronous level)
//   success     out  code matched, held until startInput falls
//   fail        out  out of tries or time, held until startInput falls
//   wrong       out  one-cycle pulse per incorrect guess
//   tries_left  out  remaining guesses
//   busy        out  high while waiting for a guess
// -----------------------------------------------------------------------------
module code_check
    import bomb_pkg::*;
#(
    parameter int CODE_W    = CODE_W_DEFAULT,
    parameter int MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           startInput,
    input  logic [CODE_W-1:0]              random,
    input  logic [CODE_W-1:0]              guess,
    input  logic                           btn_submit,
    input  logic                           time_up,
    output logic                           success,
    output logic                           fail,
    output logic                           wrong,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic                           busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

`ifdef CODE_CHECK_RETRY_EN
    localparam logic [TW-1:0] TRIES_LOAD = TW'(MAX_TRIES);
`else
    localparam logic [TW-1:0] TRIES_LOAD = TW'(1);
`endif

    cc_state_t         state_q, state_d;
    logic              start_q;       // registered copy of startInput
    logic              start_rise_q;  // registered rising-edge flag
    logic [CODE_W-1:0] target_q, target_d;
    logic [CODE_W-1:0] entry_q, entry_d;
    logic [TW-1:0]     tries_q, tries_d;
    logic              wrong_q, wrong_d;
    logic              submit;

    btn_edge u_btn_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_submit),
        .pulse_o (submit)
    );

    // The rise flag is itself registered so a round opens two edges after
    // startInput goes high (one to register, one to transition).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            start_rise_q <= 1'b0;
        end else begin
            start_q      <= startInput;
            start_rise_q <= startInput & ~start_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            entry_q  <= '0;
            tries_q  <= '0;
            wrong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            entry_q  <= entry_d;
            tries_q  <= tries_d;
            wrong_q  <= wrong_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        entry_d  = entry_q;
        tries_d  = tries_q;
        wrong_d  = 1'b0;

        if (!startInput) begin
            // Round closed by control: everything returns to idle.
            state_d = ST_IDLE;
            tries_d = '0;
        end else if (time_up && (state_q == ST_ENTRY || state_q == ST_CHECK)) begin
            // Time-out beats any same-cycle submit or match.
            state_d = ST_FAIL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise_q) begin
                        state_d  = ST_ENTRY;
                        target_d = random;
                        tries_d  = TRIES_LOAD;
                    end
                end
                ST_ENTRY: begin
                    // Submits seen in any other state are simply dropped.
                    if (submit) begin
                        entry_d = guess;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (entry_q == target_q) begin
                        state_d = ST_SUCCESS;
                    end else begin
                        wrong_d = 1'b1;
`ifdef CODE_CHECK_RETRY_EN
                        // Saturating decrement; the round fails on reaching 0.
                        if (tries_q <= TW'(1)) begin
                            tries_d = '0;
                            state_d = ST_FAIL;
                        end else begin
                            tries_d = tries_q - TW'(1);
                            state_d = ST_ENTRY;
                        end
`else
                        tries_d = '0;
                        state_d = ST_FAIL;
`endif
                    end
                end
                default: ; // SUCCESS / FAIL hold until startInput drops
            endcase
        end
    end

    // Level outputs decode the state register directly so an asynchronous
    // reset clears them without waiting for a clock edge.
    assign success    = (state_q == ST_SUCCESS);
    assign fail       = (state_q == ST_FAIL);
    assign busy       = (state_q == ST_ENTRY);
    assign wrong      = wrong_q;
    assign tries_left = tries_q;

endmodule : code_check

// File: tb/tb_code_check.sv
module tb_code_check;

    localparam int CW = 5;
    localparam int MT = 3;
    localparam int TW = $clog2(MT + 1);
`ifdef CODE_CHECK_RETRY_EN
    localparam int LOAD = MT;
`else
    localparam int LOAD = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          startInput = 1'b0;
    logic [CW-1:0] rnd = '0;
    logic [CW-1:0] guess = '0;
    logic          btn_submit = 1'b0;
    logic          time_up = 1'b0;
    logic          success, fail, wrong, busy;
    logic [TW-1:0] tries_left;

    code_check #(.CODE_W(CW), .MAX_TRIES(MT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .startInput (startInput),
        .random     (rnd),
        .guess      (guess),
        .btn_submit (btn_submit),
        .time_up    (time_up),
        .success    (success),
        .fail       (fail),
        .wrong      (wrong),
        .tries_left (tries_left),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected observable event: output levels plus the cycle it must appear.
    typedef struct {
        bit s;
        bit f;
        bit w;
        int t;
        int c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model of a round, kept at the level of "guesses and tries".
    bit m_active = 0;
    bit m_over   = 0;
    int m_target = 0;
    int m_tries  = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Monitor: any wrong pulse or rising success/fail is a DUT response.
    initial begin : monitor
        bit   ps;
        bit   pf;
        exp_t e;
        ps = 0;
        pf = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (wrong || (success && !ps) || (fail && !pf))) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d actual s=%b f=%b w=%b t=%0d required none",
                             cyc, success, fail, wrong, tries_left);
                end else begin
                    e = q.pop_front();
                    if (success !== e.s || fail !== e.f || wrong !== e.w ||
                        int'(tries_left) != e.t || cyc != e.c) begin
                        errors++;
                        $display("FAIL event actual s=%b f=%b w=%b t=%0d cyc=%0d required s=%b f=%b w=%b t=%0d cyc=%0d",
                                 success, fail, wrong, tries_left, cyc, e.s, e.f, e.w, e.t, e.c);
                    end else begin
                        $display("ok   event s=%b f=%b w=%b t=%0d cyc=%0d", success, fail, wrong, tries_left, cyc);
                    end
                end
            end
            ps = success;
            pf = fail;
        end
    end

    task automatic start_round(int code);
        @(negedge clk);
        rnd = code[CW-1:0];
        startInput = 1'b1;
        @(negedge clk);
        chk("busy_after_1_edge", busy, 0);
        @(negedge clk);
        chk("busy_after_2_edges", busy, 1);
        chk("tries_on_entry", tries_left, LOAD);
        m_active = 1;
        m_over   = 0;
        m_target = code;
        m_tries  = LOAD;
    endtask

    task automatic abort_round();
        @(negedge clk);
        startInput = 1'b0;
        @(negedge clk);
        chk("abort_success", success, 0);
        chk("abort_fail", fail, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tries", tries_left, 0);
        m_active = 0;
    endtask

    // Press the button with guess g for 'hold' cycles; tu raises time_up in
    // exactly the cycle the submit pulse is valid.
    task automatic press(int g, int hold, bit tu);
        int k;
        @(negedge clk);
        guess = g[CW-1:0];
        btn_submit = 1'b1;
        k = cyc + 1;            // first edge that samples the button high
        if (m_active && !m_over) begin
            if (tu) begin
                q.push_back('{1'b0, 1'b1, 1'b0, m_tries, k + 2});
                m_over = 1;
            end else if (g == m_target) begin
                q.push_back('{1'b1, 1'b0, 1'b0, m_tries, k + 3});
                m_over = 1;
            end else begin
                m_tries = (m_tries > 0) ? m_tries - 1 : 0;
                q.push_back('{1'b0, (m_tries == 0), 1'b1, m_tries, k + 3});
                if (m_tries == 0) m_over = 1;
            end
        end
        for (int i = 1; i <= hold + 4; i++) begin
            @(negedge clk);
            if (i == hold) btn_submit = 1'b0;
            if (tu) time_up = (cyc == k + 1);
        end
        time_up = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int code, n, g;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_success", success, 0);
        chk("rst_fail", fail, 0);
        chk("rst_wrong", wrong, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tries", tries_left, 0);
        rst_n = 1'b1;

        // Correct first guess
        start_round(5'h13);
        press(5'h13, 5, 0);
        abort_round();

        // Two wrong then correct
        start_round(5'h13);
        press(5'h01, 3, 0);
        press(5'h02, 2, 0);
        press(5'h13, 4, 0);
        abort_round();

        // Exhaustion, then an extra press that must do nothing
        start_round(5'h13);
        press(5'h01, 2, 0);
        press(5'h02, 2, 0);
        press(5'h03, 2, 0);
        press(5'h04, 2, 0);
        chk("exhaust_fail", fail, 1);
        chk("exhaust_tries", tries_left, 0);
        abort_round();

        // Time-up races a correct guess
        start_round(5'h13);
        press(5'h13, 3, 1);
        chk("timeup_success", success, 0);
        abort_round();

        // Abort mid-entry and re-enter with a new code
        start_round(5'h13);
        repeat (3) @(negedge clk);
        abort_round();
        start_round(5'h07);
        press(5'h13, 2, 0);
        press(5'h07, 2, 0);

        // Asynchronous reset mid-round clears outputs before any edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_success", success, 0);
        chk("async_fail", fail, 0);
        chk("async_busy", busy, 0);
        chk("async_tries", tries_left, 0);
        m_active = 0;
        @(negedge clk);
        startInput = 1'b0;
        rst_n = 1'b1;

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            code = $urandom_range(0, 31);
            start_round(code);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                g = ($urandom_range(0, 2) == 0) ? code : $urandom_range(0, 31);
                press(g, $urandom_range(1, 6), ($urandom_range(0, 9) == 0));
            end
            abort_round();
        end

        repeat (5) @(negedge clk);
        chk("pending_events", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_code_check
